s_pea_stream_feeder: RTL

- Producer end of the PEA streaming operand interface: sources a word stream from an upstream ready/valid port, typically the DMA or stream-in buffer.
- Drives a registered operand/valid pair into a PE input (neigh_pe_op_i / neigh_pe_op_valid_i slot), obeying the global pea_ready_i stall.
- Emits exactly cfg_len_i words per job; an internal FIFO decouples upstream burstiness from array stalls.

---
 rtl/s_pea_stream_feeder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/s_pea_stream_feeder.sv
// Producer end of the PEA operand stream: buffers upstream words in a small FIFO
// and presents exactly cfg_len_i operands to a PE, honouring the global pea_ready_i stall.
// Optional performance counters are enabled with `define S_FEEDER_PERF_CNT_EN.
module s_pea_stream_feeder #(
    parameter int N_BITS     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cfg_start_i,
    input  logic [CNT_W-1:0]  cfg_len_i,
    input  logic [N_BITS-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              pea_ready_i,
    output logic [N_BITS-1:0] pe_op_o,
    output logic              pe_op_valid_o,
    output logic              busy_o,
`ifdef S_FEEDER_PERF_CNT_EN
    output logic [31:0]       bubble_cnt_o,
    output logic [31:0]       stall_cnt_o,
`endif
    output logic              done_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [N_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [CNT_W-1:0]  r_rem_emit;
    logic [CNT_W-1:0]  r_rem_accept;
    logic [N_BITS-1:0] r_op;
    logic              r_op_valid;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_start_run;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = pea_ready_i && (r_state == ST_RUN) && !w_empty;
    assign w_start_run = (r_state == ST_IDLE) && cfg_start_i && (cfg_len_i != CNT_ZERO);

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    w_state_nxt = (cfg_len_i != CNT_ZERO) ? ST_RUN : ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_pop && (r_rem_emit == CNT_ONE)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Status and upstream handshake decode from registered state.
    always_comb begin
        busy_o     = 1'b0;
        done_o     = 1'b0;
        in_ready_o = 1'b0;
        case (r_state)
            ST_RUN: begin
                busy_o     = 1'b1;
                in_ready_o = !w_full && (r_rem_accept != CNT_ZERO);
            end
            ST_DONE: done_o = 1'b1;
            default: begin
                busy_o     = 1'b0;
                done_o     = 1'b0;
                in_ready_o = 1'b0;
            end
        endcase
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data_i;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Per-job remaining-word counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rem_emit   <= CNT_ZERO;
            r_rem_accept <= CNT_ZERO;
        end else if (w_start_run) begin
            r_rem_emit   <= cfg_len_i;
            r_rem_accept <= cfg_len_i;
        end else begin
            if (w_push) r_rem_accept <= r_rem_accept - CNT_ONE;
            if (w_pop)  r_rem_emit   <= r_rem_emit - CNT_ONE;
        end
    end

    // Operand register: frozen while the array is stalled, data held across bubbles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_op       <= {N_BITS{1'b0}};
            r_op_valid <= 1'b0;
        end else if (pea_ready_i) begin
            if (w_pop) begin
                r_op       <= r_mem[r_rd_ptr[AW-1:0]];
                r_op_valid <= 1'b1;
            end else begin
                r_op_valid <= 1'b0;
            end
        end
    end

    assign pe_op_o       = r_op;
    assign pe_op_valid_o = r_op_valid;

`ifdef S_FEEDER_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_stall_cnt;

    // Saturating bubble/stall counters, cleared at each job start.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_bubble_cnt <= 32'd0;
            r_stall_cnt  <= 32'd0;
        end else if (w_start_run) begin
            r_bubble_cnt <= 32'd0;
            r_stall_cnt  <= 32'd0;
        end else begin
            if ((r_state == ST_RUN) && pea_ready_i && w_empty && (r_bubble_cnt != 32'hFFFF_FFFF))
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if ((r_state == ST_RUN) && !pea_ready_i && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;
    assign stall_cnt_o  = r_stall_cnt;
`endif

endmodule
